// File: rtl/game_pkg.sv
// Shared game types: top-level screen selector states and the referee FSM states.
package game_pkg;

  // Top-level screen selector state, driven by the game-state selector.
  typedef enum logic [2:0] {
    START   = 3'd0,
    KEEPER  = 3'd1,
    SHOOTER = 3'd2,
    WINNER  = 3'd3,
    LOSER   = 3'd4
  } g_state;

  // Referee sequencing states.
  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    WAIT_SHOT = 3'd1,
    HOLD      = 3'd2,
    EVAL      = 3'd3,
    SWITCH    = 3'd4,
    DONE      = 3'd5
  } ref_state_t;

  // Kicks still to come in regulation, clamped at 0 once regulation is used up.
  function automatic logic [4:0] rem_kicks(input logic [4:0] rounds, input logic [4:0] kicks);
    if (kicks >= rounds) return 5'd0;
    return rounds - kicks;
  endfunction

endpackage

// File: rtl/ref_hold_timer.sv
// Result-hold timer: loaded when a shot resolves, raises o_done on the last hold cycle.
module ref_hold_timer #(
  parameter int HOLD_CYCLES = 65_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic i_clear,
  input  logic i_load,
  output logic o_done
);

  localparam int W = (HOLD_CYCLES < 2) ? 1 : $clog2(HOLD_CYCLES + 1);
  localparam logic [W-1:0] LP_LOAD = W'(HOLD_CYCLES);
  localparam logic [W-1:0] LP_ONE  = W'(1);

  logic [W-1:0] r_cnt;

  // Down-counter: load, then count to zero; clear wins over load.
  always_ff @(posedge clk) begin
    if (rst || i_clear) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= LP_LOAD;
    end else if (r_cnt != '0) begin
      r_cnt <= r_cnt - LP_ONE;
    end
  end

  // Counter holds HOLD_CYCLES on the first hold cycle, so 1 marks the last one.
  assign o_done = (r_cnt == LP_ONE);

endmodule

// File: rtl/match_referee.sv
// Penalty-shootout referee: counts shots, applies regulation and sudden-death rules,
// and tells the screen selector when to swap turns or end the match.
//
// Pulse semantics: end_gk / end_sh are single-cycle, registered, never overlapping
// with each other or with match_end. The selector must move game_state off the
// finished screen; the referee does not accept a new shot until it has done so.
module match_referee
  import game_pkg::*;
#(
  parameter int ROUNDS      = 5,
  parameter int MAX_KICKS   = 10,
  parameter int HOLD_CYCLES = 65_000_000
) (
  input  logic       clk,
  input  logic       rst,
  input  g_state     game_state,
  input  logic       shot_done,
  input  logic       shot_goal,
  output logic       end_gk,
  output logic       end_sh,
  output logic       match_end,
  output logic       match_result,
  output logic [3:0] score_player,
  output logic [3:0] score_enemy,
  output logic [3:0] kicks_player,
  output logic [3:0] kicks_enemy,
  output logic       holding,
  output ref_state_t dbg_state
);

  localparam logic [4:0] LP_R   = 5'(ROUNDS);
  localparam logic [3:0] LP_MAX = 4'(MAX_KICKS);

  ref_state_t r_state;
  logic       r_turn_sh;
  logic       r_pulsed;
  logic [3:0] r_sp, r_se, r_kp, r_ke;
  logic       r_end_gk, r_end_sh, r_match_end, r_match_result, r_holding;

  logic       w_in_play, w_abort, w_accept, w_timer_done;
  logic [4:0] w_sp5, w_se5, w_kp5, w_ke5, w_rem_p, w_rem_e;
  logic       w_early_win, w_early_loss, w_reg_decide, w_cap_tie;
  logic       w_decided, w_result;
  g_state     w_turn_gs;

  function automatic logic [3:0] sat_inc(input logic [3:0] v, input logic en);
    if (en && (v != LP_MAX)) return v + 4'd1;
    return v;
  endfunction

  assign w_in_play = (game_state == KEEPER) || (game_state == SHOOTER);
  assign w_abort   = (game_state == START) && (r_state != IDLE);
  assign w_accept  = (r_state == WAIT_SHOT) && shot_done && w_in_play;
  assign w_turn_gs = r_turn_sh ? SHOOTER : KEEPER;

  ref_hold_timer #(.HOLD_CYCLES(HOLD_CYCLES)) u_hold (
    .clk     (clk),
    .rst     (rst),
    .i_clear (w_abort),
    .i_load  (w_accept),
    .o_done  (w_timer_done)
  );

  assign w_sp5   = {1'b0, r_sp};
  assign w_se5   = {1'b0, r_se};
  assign w_kp5   = {1'b0, r_kp};
  assign w_ke5   = {1'b0, r_ke};
  assign w_rem_p = rem_kicks(LP_R, w_kp5);
  assign w_rem_e = rem_kicks(LP_R, w_ke5);

  assign w_early_win  = (w_ke5 < LP_R) && (w_sp5 > (w_se5 + w_rem_e));
  assign w_early_loss = (w_kp5 < LP_R) && (w_se5 > (w_sp5 + w_rem_p));
  assign w_reg_decide = (r_kp == r_ke) && (w_kp5 >= LP_R) && (r_sp != r_se);
  assign w_cap_tie    = (r_kp == LP_MAX) && (r_ke == LP_MAX) && (r_sp == r_se);

  // Shootout rules, first match wins; a tie at the kick cap counts as a loss.
  always_comb begin
    w_decided = 1'b1;
    w_result  = 1'b0;
    if (w_early_win) begin
      w_result = 1'b1;
    end else if (w_early_loss) begin
      w_result = 1'b0;
    end else if (w_reg_decide) begin
      w_result = (r_sp > r_se);
    end else if (w_cap_tie) begin
      w_result = 1'b0;
    end else begin
      w_decided = 1'b0;
    end
  end

  // Referee FSM with registered outputs; START from any active state aborts and clears.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state        <= IDLE;
      r_turn_sh      <= 1'b0;
      r_pulsed       <= 1'b0;
      r_sp           <= '0;
      r_se           <= '0;
      r_kp           <= '0;
      r_ke           <= '0;
      r_end_gk       <= 1'b0;
      r_end_sh       <= 1'b0;
      r_match_end    <= 1'b0;
      r_match_result <= 1'b0;
      r_holding      <= 1'b0;
    end else begin
      r_end_gk <= 1'b0;
      r_end_sh <= 1'b0;
      if (w_abort) begin
        r_state        <= IDLE;
        r_turn_sh      <= 1'b0;
        r_pulsed       <= 1'b0;
        r_sp           <= '0;
        r_se           <= '0;
        r_kp           <= '0;
        r_ke           <= '0;
        r_match_end    <= 1'b0;
        r_match_result <= 1'b0;
        r_holding      <= 1'b0;
      end else begin
        case (r_state)
          IDLE: begin
            if (w_in_play) r_state <= WAIT_SHOT;
          end
          WAIT_SHOT: begin
            if (w_accept) begin
              r_turn_sh <= (game_state == SHOOTER);
              if (game_state == SHOOTER) begin
                r_kp <= sat_inc(r_kp, 1'b1);
                r_sp <= sat_inc(r_sp, shot_goal);
              end else begin
                r_ke <= sat_inc(r_ke, 1'b1);
                r_se <= sat_inc(r_se, shot_goal);
              end
              r_holding <= 1'b1;
              r_state   <= HOLD;
            end
          end
          HOLD: begin
            if (w_timer_done) begin
              r_holding <= 1'b0;
              r_state   <= EVAL;
            end
          end
          EVAL: begin
            r_pulsed <= 1'b0;
            if (w_decided) begin
              r_match_end    <= 1'b1;
              r_match_result <= w_result;
              r_state        <= DONE;
            end else begin
              r_state <= SWITCH;
            end
          end
          SWITCH: begin
            if (!r_pulsed) begin
              r_pulsed <= 1'b1;
              if (r_turn_sh) r_end_sh <= 1'b1;
              else           r_end_gk <= 1'b1;
            end else if (game_state != w_turn_gs) begin
              r_state <= WAIT_SHOT;
            end
          end
          DONE: begin
            r_state <= DONE;
          end
          default: r_state <= IDLE;
        endcase
      end
    end
  end

  assign end_gk       = r_end_gk;
  assign end_sh       = r_end_sh;
  assign match_end    = r_match_end;
  assign match_result = r_match_result;
  assign score_player = r_sp;
  assign score_enemy  = r_se;
  assign kicks_player = r_kp;
  assign kicks_enemy  = r_ke;
  assign holding      = r_holding;
  assign dbg_state    = r_state;

endmodule

// File: tb/tb_match_referee.sv
// Bench for match_referee: directed shootouts, scoreboard on end_*/match_end events.
module tb_match_referee;
  import game_pkg::*;

  localparam int HOLD = 4;

  logic       clk;
  logic       rst;
  g_state     game_state;
  logic       shot_done;
  logic       shot_goal;
  logic       end_gk, end_sh, match_end, match_result, holding;
  logic [3:0] score_player, score_enemy, kicks_player, kicks_enemy;
  ref_state_t dbg_state;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  logic prev_me = 1'b0;

  logic [19:0] exp_q[$];
  int          exp_t_q[$];

  match_referee #(.ROUNDS(5), .MAX_KICKS(10), .HOLD_CYCLES(HOLD)) dut (
    .clk          (clk),
    .rst          (rst),
    .game_state   (game_state),
    .shot_done    (shot_done),
    .shot_goal    (shot_goal),
    .end_gk       (end_gk),
    .end_sh       (end_sh),
    .match_end    (match_end),
    .match_result (match_result),
    .score_player (score_player),
    .score_enemy  (score_enemy),
    .kicks_player (kicks_player),
    .kicks_enemy  (kicks_enemy),
    .holding      (holding),
    .dbg_state    (dbg_state)
  );

  // Clock and cycle counter
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Watchdog
  initial begin
    #300000;
    $display("FAIL watchdog: actual=no_finish required=finish");
    $fatal(1, "watchdog expired");
  end

  function automatic logic [19:0] pack(input logic gk, input logic sh, input logic me,
                                       input logic res, input logic [3:0] sp,
                                       input logic [3:0] se, input logic [3:0] kp,
                                       input logic [3:0] ke);
    return {gk, sh, me, res, sp, se, kp, ke};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // All counters and status outputs idle.
  task automatic clear_chk(input string name);
    chk(name, {end_gk, end_sh, match_end, match_result, holding,
               score_player, score_enemy, kicks_player, kicks_enemy}, 32'd0);
  endtask

  // Monitor: every end pulse or match_end rise pops one expected event.
  always @(negedge clk) begin
    logic [19:0] act, e;
    int t;
    if (!rst && (end_gk || end_sh || (match_end && !prev_me))) begin
      act = pack(end_gk, end_sh, match_end, match_result,
                 score_player, score_enemy, kicks_player, kicks_enemy);
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_event: actual=%05h at cycle %0d required=none", act, cyc);
      end else begin
        e = exp_q.pop_front();
        t = exp_t_q.pop_front();
        if (act !== e || cyc != t) begin
          errors++;
          $display("FAIL event: actual=%05h@%0d required=%05h@%0d", act, cyc, e, t);
        end
      end
    end
    prev_me = match_end;
  end

  task automatic pulse_shot(input logic goal);
    shot_done = 1'b1;
    shot_goal = goal;
    @(negedge clk);
    shot_done = 1'b0;
    shot_goal = 1'b0;
  endtask

  // One scored shot on the current screen; expected event pushed before the pulse.
  task automatic shot(input logic goal, input logic extra, input logic me, input logic res,
                      input logic [3:0] sp, input logic [3:0] se,
                      input logic [3:0] kp, input logic [3:0] ke);
    logic gk_turn;
    bit   seen;
    gk_turn = (game_state == KEEPER);
    exp_q.push_back(pack(!me && gk_turn, !me && !gk_turn, me, res, sp, se, kp, ke));
    exp_t_q.push_back(me ? cyc + HOLD + 2 : cyc + HOLD + 3);
    pulse_shot(goal);
    if (extra) begin
      @(negedge clk);
      chk("holding_in_hold", {31'd0, holding}, 32'd1);
      pulse_shot(1'b1);
    end
    seen = 1'b0;
    for (int k = 0; k < 20 && !seen; k++) begin
      @(negedge clk);
      if (end_gk || end_sh || match_end) seen = 1'b1;
    end
    if (!seen) begin
      checks++;
      errors++;
      $display("FAIL shot_timeout: actual=no_event required=event");
    end else if (!me) begin
      game_state = gk_turn ? SHOOTER : KEEPER;
      @(negedge clk);
    end
  endtask

  task automatic back_to_start(input string name);
    game_state = START;
    @(negedge clk);
    clear_chk(name);
    chk({name, "_state"}, {29'd0, dbg_state}, {29'd0, IDLE});
  endtask

  initial begin
    rst        = 1'b1;
    game_state = START;
    shot_done  = 1'b0;
    shot_goal  = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    clear_chk("reset_outputs");
    chk("reset_state", {29'd0, dbg_state}, {29'd0, IDLE});

    // Early win: shooter goals vs keeper saves, decided after the 6th shot.
    game_state = SHOOTER;
    repeat (2) @(negedge clk);
    shot(1, 0, 0, 0, 4'd1, 4'd0, 4'd1, 4'd0);
    shot(0, 0, 0, 0, 4'd1, 4'd0, 4'd1, 4'd1);
    shot(1, 0, 0, 0, 4'd2, 4'd0, 4'd2, 4'd1);
    shot(0, 0, 0, 0, 4'd2, 4'd0, 4'd2, 4'd2);
    shot(1, 0, 0, 0, 4'd3, 4'd0, 4'd3, 4'd2);
    shot(0, 0, 1, 1, 4'd3, 4'd0, 4'd3, 4'd3);
    repeat (3) @(negedge clk);
    chk("early_win_hold", {30'd0, match_end, match_result}, 32'd3);
    back_to_start("after_early_win");

    // Regulation tie 5:5 then sudden death 6:5.
    game_state = SHOOTER;
    repeat (2) @(negedge clk);
    for (int i = 1; i <= 5; i++) begin
      shot(1, 0, 0, 0, 4'(i), 4'(i - 1), 4'(i), 4'(i - 1));
      shot(1, 0, 0, 0, 4'(i), 4'(i), 4'(i), 4'(i));
    end
    shot(1, 0, 0, 0, 4'd6, 4'd5, 4'd6, 4'd5);
    shot(0, 0, 1, 1, 4'd6, 4'd5, 4'd6, 4'd6);
    back_to_start("after_sudden_death");

    // Tie all the way to the kick cap: loss.
    game_state = SHOOTER;
    repeat (2) @(negedge clk);
    for (int i = 1; i <= 10; i++) begin
      shot(1, 0, 0, 0, 4'(i), 4'(i - 1), 4'(i), 4'(i - 1));
      if (i < 10) shot(1, 0, 0, 0, 4'(i), 4'(i), 4'(i), 4'(i));
      else        shot(1, 0, 1, 0, 4'd10, 4'd10, 4'd10, 4'd10);
    end
    repeat (2) @(negedge clk);
    chk("cap_tie_hold", {30'd0, match_end, match_result}, 32'd2);
    back_to_start("after_cap_tie");

    // Keeper first, extra shot_done during HOLD must not count.
    game_state = KEEPER;
    repeat (2) @(negedge clk);
    shot(1, 1, 0, 0, 4'd0, 4'd1, 4'd0, 4'd1);
    shot(0, 0, 0, 0, 4'd0, 4'd1, 4'd1, 4'd1);

    // Abort mid-HOLD: cleared next cycle, no turn pulse.
    pulse_shot(1'b1);
    @(negedge clk);
    chk("abort_pre_holding", {31'd0, holding}, 32'd1);
    chk("abort_pre_counts", {score_enemy, kicks_enemy}, {24'd0, 4'd2, 4'd2});
    game_state = START;
    @(negedge clk);
    clear_chk("abort_hold");
    repeat (10) @(negedge clk);
    chk("abort_state", {29'd0, dbg_state}, {29'd0, IDLE});

    // Shots on START or WINNER screens are ignored.
    pulse_shot(1'b1);
    repeat (2) @(negedge clk);
    clear_chk("shot_in_start");
    game_state = SHOOTER;
    repeat (2) @(negedge clk);
    game_state = WINNER;
    @(negedge clk);
    pulse_shot(1'b1);
    repeat (8) @(negedge clk);
    clear_chk("shot_in_winner");
    chk("winner_state", {29'd0, dbg_state}, {29'd0, WAIT_SHOT});
    game_state = SHOOTER;
    @(negedge clk);
    shot(1, 0, 0, 0, 4'd1, 4'd0, 4'd1, 4'd0);

    // Reset in the middle of a hold.
    pulse_shot(1'b1);
    @(negedge clk);
    chk("pre_rst_kicks", {24'd0, kicks_player, kicks_enemy}, {24'd0, 4'd1, 4'd1});
    rst = 1'b1;
    @(negedge clk);
    clear_chk("mid_rst");
    game_state = START;
    rst = 1'b0;
    repeat (12) @(negedge clk);
    clear_chk("post_rst");

    chk("queue_drained", exp_q.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
